// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory controller: FSM encoding, access-width
// codes, boolean literals, the IO-space selector and byte-lane helpers.
package mem_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    IFETCH = 3'd1,
    LOAD   = 3'd2,
    STORE  = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [1:0] W_BYTE = 2'd0;
  localparam logic [1:0] W_HALF = 2'd1;
  localparam logic [1:0] W_WORD = 2'd2;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam logic [1:0] IO_SEL_DEF  = 2'b11;
  localparam logic [2:0] FETCH_BYTES = 3'd4;

  // Width code 3 is not a legal access size and falls through to a word.
  function automatic logic [2:0] width_bytes(input logic [1:0] w);
    case (w)
      W_BYTE:  return 3'd1;
      W_HALF:  return 3'd2;
      W_WORD:  return 3'd4;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] w,
                                           input logic [2:0]  idx,
                                           input logic [7:0]  b);
    logic [5:0] sh;
    sh = {idx, 3'b000};
    return (w & ~(32'h0000_00ff << sh)) | ({24'd0, b} << sh);
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial RAM arbiter: serves instruction fetches and load/store requests
// one byte per cycle, with IO write-buffer back-pressure, rollback and rdy freeze.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter logic [1:0] IO_SEL = IO_SEL_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  input  logic        if_enable,
  input  logic [31:0] if_addr,
  output logic        if_valid,
  output logic [31:0] if_data,
  input  logic        ls_enable,
  input  logic        ls_wr,
  input  logic [1:0]  ls_width,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_valid,
  output logic [31:0] ls_rdata,
  input  logic        rollback
);

  state_t      state;
  logic [2:0]  cnt;
  logic [2:0]  len;
  logic [31:0] base;
  logic [23:0] wdata_sr;
  logic [31:0] buffer;
  logic        mem_wr_q;

  logic        io_stall;
  logic [2:0]  cnt_nxt;
  logic [2:0]  cnt_m1;
  logic [31:0] next_a;
  logic [31:0] buffer_nxt;

  // A store into IO space waits in place while the IO buffer is full.
  assign io_stall   = (state == STORE) && (mem_a[17:16] == IO_SEL) && io_buffer_full;
  assign mem_wr     = mem_wr_q && !io_stall;
  assign cnt_nxt    = cnt + 3'd1;
  assign cnt_m1     = cnt - 3'd1;
  assign next_a     = base + {29'd0, cnt} + 32'd1;
  assign buffer_nxt = put_byte(buffer, cnt_m1, mem_din);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 3'd0;
      len      <= 3'd0;
      base     <= 32'd0;
      wdata_sr <= 24'd0;
      buffer   <= 32'd0;
      mem_a    <= 32'd0;
      mem_dout <= 8'd0;
      mem_wr_q <= FALSE;
      if_valid <= FALSE;
      if_data  <= 32'd0;
      ls_valid <= FALSE;
      ls_rdata <= 32'd0;
    end else if (rdy) begin
      case (state)
        IDLE: begin
          mem_a    <= 32'd0;
          mem_wr_q <= FALSE;
          if (!rollback && (ls_enable || if_enable)) begin
            cnt    <= 3'd0;
            buffer <= 32'd0;
            if (ls_enable) begin
              base     <= ls_addr;
              mem_a    <= ls_addr;
              len      <= width_bytes(ls_width);
              wdata_sr <= ls_wdata[31:8];
              if (ls_wr) begin
                state    <= STORE;
                mem_dout <= ls_wdata[7:0];
                mem_wr_q <= TRUE;
              end else begin
                state <= LOAD;
              end
            end else begin
              base  <= if_addr;
              mem_a <= if_addr;
              len   <= FETCH_BYTES;
              state <= IFETCH;
            end
          end
        end

        // Reads run one edge past the last address so the final byte can land.
        IFETCH, LOAD: begin
          if (rollback) begin
            state    <= IDLE;
            mem_a    <= 32'd0;
            mem_wr_q <= FALSE;
          end else begin
            if (cnt != 3'd0) buffer <= buffer_nxt;
            if (cnt == len) begin
              state <= DONE;
              mem_a <= 32'd0;
              if (state == IFETCH) begin
                if_valid <= TRUE;
                if_data  <= buffer_nxt;
              end else begin
                ls_valid <= TRUE;
                ls_rdata <= buffer_nxt;
              end
            end else begin
              cnt <= cnt_nxt;
              if (cnt_nxt < len) mem_a <= next_a;
            end
          end
        end

        STORE: begin
          if (!io_stall) begin
            if (cnt_nxt == len) begin
              state    <= DONE;
              mem_a    <= 32'd0;
              mem_wr_q <= FALSE;
              ls_valid <= TRUE;
            end else begin
              cnt      <= cnt_nxt;
              mem_a    <= next_a;
              mem_dout <= wdata_sr[7:0];
              wdata_sr <= {8'd0, wdata_sr[23:8]};
            end
          end
        end

        DONE: begin
          state    <= IDLE;
          if_valid <= FALSE;
          ls_valid <= FALSE;
          mem_wr_q <= FALSE;
        end

        default: begin
          state    <= IDLE;
          mem_a    <= 32'd0;
          mem_wr_q <= FALSE;
        end
      endcase
    end
  end

endmodule
